me_sad_search: RTL



---
 rtl/me_sad_search.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/me_sad_search.sv
// me_sad_search: full-search SAD motion estimator with partial-SAD
// candidate abort and threshold-based early termination.
module me_sad_search #(
    parameter int BLK_DIM    = 16,
    parameter int SEARCH_DIM = 48,
    parameter int PIX_W      = 8,
    localparam int NPOS  = SEARCH_DIM - BLK_DIM + 1,
    localparam int SAD_W = PIX_W + 2 * $clog2(BLK_DIM),
    localparam int POS_W = $clog2(NPOS),
    localparam int RA_W  = $clog2(SEARCH_DIM),
    localparam int BA_W  = $clog2(BLK_DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SAD_W-1:0]         early_thr,
    output logic [BA_W-1:0]          cur_addr,
    input  logic [BLK_DIM*PIX_W-1:0] cur_row,
    output logic [RA_W-1:0]          srch_row_addr,
    output logic [RA_W-1:0]          srch_col_addr,
    input  logic [BLK_DIM*PIX_W-1:0] srch_row,
    output logic                     ready,
    output logic                     valid,
    output logic [SAD_W-1:0]         min_sad,
    output logic [POS_W-1:0]         best_x,
    output logic [POS_W-1:0]         best_y,
    output logic                     early_hit
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SAD_W-1:0] thr_q, thr_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [POS_W-1:0] bx_q, bx_d;
    logic [POS_W-1:0] by_q, by_d;
    logic [POS_W-1:0] cx_q, cx_d;
    logic [POS_W-1:0] cy_q, cy_d;
    logic [BA_W-1:0]  row_q, row_d;
    logic [SAD_W-1:0] acc_q, acc_d;
    logic [SAD_W-1:0] min_sad_q, min_sad_d;
    logic [POS_W-1:0] best_x_q, best_x_d;
    logic [POS_W-1:0] best_y_q, best_y_d;
    logic             early_q, early_d;

    logic [SAD_W-1:0] row_sad;
    logic [SAD_W-1:0] acc_n;
    logic [SAD_W-1:0] new_best;
    logic [POS_W-1:0] new_bx;
    logic [POS_W-1:0] new_by;
    logic             running;
    logic             last_row;
    logic             last_pos;
    logic             upd;
    logic             done_now;
    logic             early_now;
    logic             adv_now;

    function automatic logic [PIX_W-1:0] absd(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        return (a > b) ? a - b : b - a;
    endfunction

    assign running       = state_q == S_RUN;
    assign ready         = state_q == S_IDLE;
    assign valid         = state_q == S_DONE;
    assign cur_addr      = running ? row_q : '0;
    assign srch_row_addr = running ? RA_W'(cy_q) + RA_W'(row_q) : '0;
    assign srch_col_addr = running ? RA_W'(cx_q) : '0;
    assign min_sad       = min_sad_q;
    assign best_x        = best_x_q;
    assign best_y        = best_y_q;
    assign early_hit     = early_q;

    always_comb begin
        row_sad = '0;
        for (int k = 0; k < BLK_DIM; k++) begin
            row_sad = row_sad + SAD_W'(absd(cur_row[k*PIX_W +: PIX_W],
                                            srch_row[k*PIX_W +: PIX_W]));
        end
    end

    assign acc_n    = acc_q + row_sad;
    assign last_row = row_q == BA_W'(BLK_DIM - 1);
    assign last_pos = (cx_q == POS_W'(NPOS - 1)) && (cy_q == POS_W'(NPOS - 1));
    assign upd      = last_row && (acc_n < best_sad_q);
    assign new_best = upd ? acc_n : best_sad_q;
    assign new_bx   = upd ? cx_q : bx_q;
    assign new_by   = upd ? cy_q : by_q;

    // An aborted candidate can never beat best_sad, so only completed
    // candidates are eligible for the threshold test.
    always_comb begin
        done_now  = 1'b0;
        early_now = 1'b0;
        adv_now   = 1'b0;
        if (last_row) begin
            if ((thr_q != '0) && (new_best <= thr_q)) begin
                done_now  = 1'b1;
                early_now = 1'b1;
            end else if (last_pos) begin
                done_now = 1'b1;
            end else begin
                adv_now = 1'b1;
            end
        end else if (acc_n >= best_sad_q) begin
            if (last_pos) begin
                done_now = 1'b1;
            end else begin
                adv_now = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        best_sad_d = best_sad_q;
        bx_d       = bx_q;
        by_d       = by_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_d      = row_q;
        acc_d      = acc_q;
        min_sad_d  = min_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        early_d    = early_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    thr_d      = early_thr;
                    best_sad_d = '1;
                    bx_d       = '0;
                    by_d       = '0;
                    cx_d       = '0;
                    cy_d       = '0;
                    row_d      = '0;
                    acc_d      = '0;
                    min_sad_d  = '0;
                    best_x_d   = '0;
                    best_y_d   = '0;
                    early_d    = 1'b0;
                end
            end
            S_RUN: begin
                best_sad_d = new_best;
                bx_d       = new_bx;
                by_d       = new_by;
                if (done_now) begin
                    state_d   = S_DONE;
                    min_sad_d = new_best;
                    best_x_d  = new_bx;
                    best_y_d  = new_by;
                    early_d   = early_now;
                end else if (adv_now) begin
                    row_d = '0;
                    acc_d = '0;
                    if (cx_q == POS_W'(NPOS - 1)) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                    acc_d = acc_n;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            thr_q      <= '0;
            best_sad_q <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            min_sad_q  <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            best_sad_q <= best_sad_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            min_sad_q  <= min_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            early_q    <= early_d;
        end
    end

endmodule
